gauss_stream: RTL and testbench

- Streaming, parametrised 5x5 2D convolution filter for the camera video path; a raster-order successor to the fixed-kernel combinational Gaussian.
- Holds four lines of history in internal line buffers, so callers supply one pixel per cycle instead of five full rows.
- Coefficients are signed and runtime-programmable through double-buffered registers that commit at frame start, with a bypass mode and a fixed 3-cycle pipeline.

---
 rtl/gauss_stream.sv | 277 +++++++++++++++++++++++++++
 tb/tb_gauss_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_stream.sv
`default_nettype none
// ============================================================================
// Module   : gauss_stream
// Brief    : Streaming 5x5 convolution with line buffers, programmable signed
//            double-buffered coefficients, bypass mode and 3-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module gauss_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    input  logic              en_filter,
    input  logic              coef_we,
    input  logic [4:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eol,
    output logic [DATA_W-1:0] out_data
);

    localparam int c_ntap   = 25;
    localparam int c_col_w  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_prod_w = DATA_W + COEF_W + 1;
    localparam int c_acc_w  = DATA_W + COEF_W + 6;
    localparam logic signed [c_acc_w-1:0] c_pix_max = c_acc_w'((1 << DATA_W) - 1);

    function automatic int binom_1d(input int k);
        case (k)
            0, 4:    return 1;
            1, 3:    return 4;
            default: return 6;
        endcase
    endfunction

    function automatic logic [COEF_W-1:0] binom_tap(input int idx);
        return COEF_W'(binom_1d(idx / 5) * binom_1d(idx % 5));
    endfunction

    // ------------------------------------------------------------------
    // Coefficient banks
    // ------------------------------------------------------------------
    logic [COEF_W-1:0] r_coef_shadow [c_ntap];
    logic [COEF_W-1:0] r_coef_act    [c_ntap];
    logic [COEF_W-1:0] w_shadow_nxt  [c_ntap];
    logic [COEF_W-1:0] w_coef        [c_ntap];
    logic              w_commit;

    assign w_commit = in_valid && in_sof;

    // A write landing in the commit cycle must be visible to the committing pixel.
    always_comb begin
        for (int i = 0; i < c_ntap; i++) begin
            w_shadow_nxt[i] = r_coef_shadow[i];
        end
        if (coef_we && (coef_addr < 5'd25)) begin
            w_shadow_nxt[coef_addr] = coef_wdata;
        end
        for (int i = 0; i < c_ntap; i++) begin
            w_coef[i] = w_commit ? w_shadow_nxt[i] : r_coef_act[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_ntap; i++) begin
                r_coef_shadow[i] <= binom_tap(i);
                r_coef_act[i]    <= binom_tap(i);
            end
        end else begin
            for (int i = 0; i < c_ntap; i++) begin
                r_coef_shadow[i] <= w_shadow_nxt[i];
                if (w_commit) begin
                    r_coef_act[i] <= w_shadow_nxt[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Raster position
    // ------------------------------------------------------------------
    logic [c_col_w-1:0] r_col;
    logic [2:0]         r_row;
    logic [c_col_w-1:0] w_col;
    logic [2:0]         w_row;
    logic               w_eol;

    assign w_col = in_sof ? '0 : r_col;
    assign w_row = in_sof ? 3'd0 : r_row;
    assign w_eol = (w_col == c_col_w'(IMG_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= 3'd0;
        end else if (in_valid) begin
            if (w_eol) begin
                r_col <= '0;
                r_row <= (w_row == 3'd4) ? w_row : w_row + 3'd1;
            end else begin
                r_col <= w_col + c_col_w'(1);
                r_row <= w_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: buffer k holds the row k+1 lines above the input
    // ------------------------------------------------------------------
    logic [4*DATA_W-1:0] w_lb_rd;
    logic [DATA_W-1:0]   w_colv [5];

    always_comb begin
        w_colv[4] = in_data;
        for (int k = 0; k < 4; k++) begin
            w_colv[3-k] = w_lb_rd[k*DATA_W +: DATA_W];
        end
    end

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_lb
            logic [DATA_W-1:0] r_mem [IMG_W];

            assign w_lb_rd[k*DATA_W +: DATA_W] = r_mem[w_col];

            always_ff @(posedge clk) begin
                if (in_valid) begin
                    r_mem[w_col] <= w_colv[4-k];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Window columns and zero padding
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_win [5][4];
    logic [DATA_W-1:0] w_tap [c_ntap];

    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][3] <= w_colv[r];
            end
        end
    end

    // Stale window columns from the previous line are masked out here.
    always_comb begin
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                w_tap[5*r+c] = r_win[r][c];
            end
            w_tap[5*r+4] = w_colv[r];
            for (int c = 0; c < 5; c++) begin
                if ((int'(w_row) < 4 - r) || (int'(w_col) < 4 - c)) begin
                    w_tap[5*r+c] = '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: products
    // ------------------------------------------------------------------
    logic signed [c_prod_w-1:0] w_prod    [c_ntap];
    logic signed [c_prod_w-1:0] r_s1_prod [c_ntap];
    logic [DATA_W-1:0]          r_s1_ctr;
    logic                       r_s1_en;
    logic                       r_s1_vld;
    logic                       r_s1_sof;
    logic                       r_s1_eol;

    always_comb begin
        for (int i = 0; i < c_ntap; i++) begin
            w_prod[i] = $signed({{(c_prod_w-DATA_W){1'b0}}, w_tap[i]})
                      * $signed({{(c_prod_w-COEF_W){w_coef[i][COEF_W-1]}}, w_coef[i]});
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: per-row partial sums
    // ------------------------------------------------------------------
    logic signed [c_acc_w-1:0] w_row_sum [5];
    logic signed [c_acc_w-1:0] r_s2_sum  [5];
    logic [DATA_W-1:0]         r_s2_ctr;
    logic                      r_s2_en;
    logic                      r_s2_vld;
    logic                      r_s2_sof;
    logic                      r_s2_eol;

    always_comb begin
        for (int r = 0; r < 5; r++) begin
            w_row_sum[r] = '0;
            for (int c = 0; c < 5; c++) begin
                w_row_sum[r] = w_row_sum[r] + c_acc_w'(r_s1_prod[5*r+c]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: final sum, shift, clamp
    // ------------------------------------------------------------------
    logic signed [c_acc_w-1:0] w_acc;
    logic signed [c_acc_w-1:0] w_res;
    logic [DATA_W-1:0]         w_clamp;

    always_comb begin
        w_acc = '0;
        for (int r = 0; r < 5; r++) begin
            w_acc = w_acc + r_s2_sum[r];
        end
        w_res = w_acc >>> SHIFT;
        if (w_res < 0) begin
            w_clamp = '0;
        end else if (w_res > c_pix_max) begin
            w_clamp = '1;
        end else begin
            w_clamp = w_res[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_ntap; i++) begin
            r_s1_prod[i] <= w_prod[i];
        end
        r_s1_ctr <= w_tap[12];
        r_s1_en  <= en_filter;
        for (int r = 0; r < 5; r++) begin
            r_s2_sum[r] <= w_row_sum[r];
        end
        r_s2_ctr <= r_s1_ctr;
        r_s2_en  <= r_s1_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_sof  <= 1'b0;
            r_s1_eol  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_sof  <= 1'b0;
            r_s2_eol  <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_data  <= '0;
        end else begin
            r_s1_vld  <= in_valid;
            r_s1_sof  <= in_valid && in_sof;
            r_s1_eol  <= in_valid && w_eol;
            r_s2_vld  <= r_s1_vld;
            r_s2_sof  <= r_s1_vld && r_s1_sof;
            r_s2_eol  <= r_s1_vld && r_s1_eol;
            out_valid <= r_s2_vld;
            out_sof   <= r_s2_vld && r_s2_sof;
            out_eol   <= r_s2_vld && r_s2_eol;
            if (r_s2_vld) begin
                out_data <= r_s2_en ? w_clamp : r_s2_ctr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gauss_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_gauss_stream
// Brief    : Directed self-checking bench for gauss_stream on an 8x8 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gauss_stream;

    localparam int c_w   = 8;
    localparam int c_pix = 64;

    localparam int P_FLAT100 = 0;
    localparam int P_IMP     = 1;
    localparam int P_FLAT255 = 2;
    localparam int P_FLAT50  = 3;
    localparam int P_RAMP    = 4;

    // kernel modes: 0 binomial, 1 all 127, 2 only centre = -1, 3 leave as is
    typedef struct {
        int km;
        int pat;
        int en;
        int gaps;
        int r;
        int c;
        int exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       en_filter = 1'b1;
    logic       coef_we = 1'b0;
    logic [4:0] coef_addr = 5'd0;
    logic [7:0] coef_wdata = 8'd0;
    logic       out_valid;
    logic       out_sof;
    logic       out_eol;
    logic [7:0] out_data;

    int errs = 0;
    int checks = 0;
    int ncap = 0;
    logic [7:0] cap_d   [c_pix];
    logic       cap_sof [c_pix];
    logic       cap_eol [c_pix];

    gauss_stream #(
        .DATA_W(8),
        .IMG_W (c_w),
        .COEF_W(8),
        .SHIFT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .en_filter (en_filter),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) begin
            if (ncap < c_pix) begin
                cap_d[ncap]   = out_data;
                cap_sof[ncap] = out_sof;
                cap_eol[ncap] = out_eol;
            end
            ncap++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int b1d(input int k);
        case (k)
            0, 4:    return 1;
            1, 3:    return 4;
            default: return 6;
        endcase
    endfunction

    function automatic logic [7:0] kval(input int mode, input int i);
        case (mode)
            0:       return 8'(b1d(i / 5) * b1d(i % 5));
            1:       return 8'd127;
            default: return (i == 12) ? 8'hFF : 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] pix(input int pat, input int r, input int c);
        case (pat)
            P_FLAT100: return 8'd100;
            P_IMP:     return (r == 2 && c == 2) ? 8'd255 : 8'd0;
            P_FLAT255: return 8'd255;
            P_FLAT50:  return 8'd50;
            default:   return 8'(c + 8 * r);
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            coef_we  = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit sof, input bit en,
                        input bit we, input int waddr, input int wdata);
        @(negedge clk);
        in_valid   = 1'b1;
        in_sof     = sof;
        in_data    = d;
        en_filter  = en;
        coef_we    = we;
        coef_addr  = 5'(waddr);
        coef_wdata = 8'(wdata);
    endtask

    task automatic set_kernel(input int mode);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            in_valid   = 1'b0;
            in_sof     = 1'b0;
            coef_we    = 1'b1;
            coef_addr  = 5'(i);
            coef_wdata = kval(mode, i);
        end
        idle(1);
    endtask

    // wk: pixel index carrying a simultaneous coefficient write (-1 = none)
    task automatic run_frame(input int pat, input int en, input int gaps,
                             input int wk, input int waddr, input int wdata);
        int bad;
        ncap = 0;
        for (int k = 0; k < c_pix; k++) begin
            if (gaps != 0 && k > 0) idle($urandom_range(0, 2));
            send(pix(pat, k / c_w, k % c_w), k == 0, en != 0, k == wk, waddr, wdata);
        end
        idle(6);
        chk("frame_len", ncap, c_pix);
        bad = 0;
        for (int k = 0; k < c_pix; k++) begin
            if (cap_sof[k] !== (k == 0)) bad++;
            if (cap_eol[k] !== ((k % c_w) == c_w - 1)) bad++;
        end
        chk("sof_eol_flags", bad, 0);
    endtask

    vec_t vt[16];

    initial begin
        vt[0]  = '{3, P_FLAT100, 1, 0, 4, 4, 100};
        vt[1]  = '{0, P_FLAT100, 1, 1, 0, 0, 0};
        vt[2]  = '{0, P_FLAT100, 1, 1, 0, 1, 1};
        vt[3]  = '{0, P_FLAT100, 1, 1, 1, 1, 9};
        vt[4]  = '{0, P_FLAT100, 1, 0, 4, 0, 6};
        vt[5]  = '{0, P_IMP,     1, 0, 4, 4, 35};
        vt[6]  = '{0, P_IMP,     1, 0, 4, 3, 23};
        vt[7]  = '{1, P_FLAT255, 1, 0, 4, 4, 255};
        vt[8]  = '{1, P_FLAT255, 1, 0, 0, 0, 126};
        vt[9]  = '{2, P_FLAT50,  1, 0, 4, 4, 0};
        vt[10] = '{0, P_RAMP,    1, 0, 4, 4, 18};
        vt[11] = '{0, P_RAMP,    0, 1, 3, 5, 11};
        vt[12] = '{0, P_RAMP,    0, 0, 2, 4, 2};
        vt[13] = '{0, P_RAMP,    0, 0, 4, 1, 0};
        vt[14] = '{0, P_RAMP,    0, 0, 1, 5, 0};
        vt[15] = '{0, P_RAMP,    0, 0, 7, 7, 45};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sof",   int'(out_sof),   0);
        chk("rst_out_eol",   int'(out_eol),   0);
        chk("rst_out_data",  int'(out_data),  0);
        rst_n = 1'b1;
        idle(2);

        // Single pixel, then watch for the output exactly three cycles later
        send(8'd100, 1'b1, 1'b1, 1'b0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            chk($sformatf("latency_valid_c%0d", k), int'(out_valid), (k == 3) ? 1 : 0);
            if (k == 3) begin
                chk("latency_sof",  int'(out_sof),  1);
                chk("latency_data", int'(out_data), 0);
            end
        end

        for (int v = 0; v < 16; v++) begin
            if (vt[v].km != 3) set_kernel(vt[v].km);
            run_frame(vt[v].pat, vt[v].en, vt[v].gaps, -1, 0, 0);
            chk($sformatf("vec%0d_px(%0d,%0d)", v, vt[v].r, vt[v].c),
                int'(cap_d[vt[v].r * c_w + vt[v].c]), vt[v].exp);
        end

        // Mid-frame shadow write must not affect the running frame
        set_kernel(0);
        run_frame(P_IMP, 1, 0, 10, 12, 0);
        chk("midframe_write_same_frame", int'(cap_d[36]), 35);
        run_frame(P_IMP, 1, 0, 5, 25, 100);
        chk("committed_centre_zero", int'(cap_d[36]), 0);
        chk("committed_other_tap",   int'(cap_d[35]), 23);
        run_frame(P_IMP, 1, 0, 0, 12, 36);
        chk("write_in_commit_cycle", int'(cap_d[36]), 35);

        // Reset mid-frame with pixels in flight; coefficients must reload
        set_kernel(1);
        ncap = 0;
        for (int k = 0; k < 20; k++) begin
            send(8'd100, k == 0, 1'b1, 1'b0, 0, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data",  int'(out_data),  0);
        ncap = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        chk("midrst_no_stale_valid", ncap, 0);
        run_frame(P_FLAT100, 1, 0, -1, 0, 0);
        chk("post_rst_flat_centre", int'(cap_d[36]), 100);
        chk("post_rst_flat_corner", int'(cap_d[0]),  0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
